// File: rtl/input_demux.sv
// Input demultiplexer: routes the shared ui_in/uio_in pins to one selected user design,
// holding every other design in reset, with debounced and drained select switching.
module input_demux #(
   parameter int NUM_DESIGNS   = 16,
   parameter int SEL_W         = 4,
   parameter int IN_W          = 8,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int RST_CYCLES    = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [SEL_W-1:0]            design_sel_in,
   input  logic [IN_W-1:0]             ui_in,
   input  logic [IN_W-1:0]             uio_in,
   output logic [NUM_DESIGNS*IN_W-1:0] ui_out,
   output logic [NUM_DESIGNS*IN_W-1:0] uio_out,
   output logic [NUM_DESIGNS-1:0]      design_rst_out,
   output logic [SEL_W-1:0]            design_sel_out,
   output logic                        switching_out
);

   localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DRAIN    = 2'd1,
      HOLD_RST = 2'd2
   } state_t;

   logic [SEL_W-1:0]            sync_q [SYNC_STAGES];
   logic [SEL_W-1:0]            sync_d [SYNC_STAGES];
   logic [SEL_W-1:0]            sel_s;
   logic [SEL_W-1:0]            cand_q, cand_d;
   logic [STAB_W-1:0]           stab_q, stab_d;
   logic                        accept;
   state_t                      state_q, state_d;
   logic [SEL_W-1:0]            cur_q, cur_d;
   logic [SEL_W-1:0]            tgt_q, tgt_d;
   logic [HOLD_W-1:0]           hold_q, hold_d;
   logic [NUM_DESIGNS*IN_W-1:0] ui_q, ui_d;
   logic [NUM_DESIGNS*IN_W-1:0] uio_q, uio_d;
   logic [NUM_DESIGNS-1:0]      drst_q, drst_d;
   logic                        sw_q, sw_d;

   always_comb begin
      sync_d[0] = design_sel_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign sel_s = sync_q[SYNC_STAGES-1];

   // Debounce runs in every state; only RUN may act on a settled code.
   always_comb begin
      cand_d = cand_q;
      stab_d = stab_q;
      if (sel_s != cand_q) begin
         cand_d = sel_s;
         stab_d = '0;
      end else if (stab_q != STAB_MAX) begin
         stab_d = stab_q + 1'b1;
      end
   end

   assign accept = (state_q == RUN) && (stab_q == STAB_MAX) && (cand_q != cur_q);

   // The target is captured at accept so a code arriving in that same cycle cannot leak in.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      tgt_d   = tgt_q;
      hold_d  = hold_q;
      case (state_q)
         RUN: begin
            if (accept) begin
               state_d = DRAIN;
               tgt_d   = cand_q;
            end
         end
         DRAIN: begin
            cur_d   = tgt_q;
            hold_d  = '0;
            state_d = HOLD_RST;
         end
         HOLD_RST: begin
            if (hold_q == HOLD_MAX) begin
               state_d = RUN;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = HOLD_RST;
            hold_d  = '0;
         end
      endcase
   end

   // Outputs are built from the next state so they line up with state_q; an out-of-range
   // code matches no slot and therefore leaves every design parked.
   always_comb begin
      ui_d   = '0;
      uio_d  = '0;
      drst_d = '1;
      for (int k = 0; k < NUM_DESIGNS; k++) begin
         if ((state_d == RUN) && (32'(cur_d) == 32'(k))) begin
            ui_d[k*IN_W +: IN_W]  = ui_in;
            uio_d[k*IN_W +: IN_W] = uio_in;
            drst_d[k]             = 1'b0;
         end
      end
      sw_d = (state_d != RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         cand_q  <= '0;
         stab_q  <= '0;
         state_q <= HOLD_RST;
         cur_q   <= '0;
         tgt_q   <= '0;
         hold_q  <= '0;
         ui_q    <= '0;
         uio_q   <= '0;
         drst_q  <= '1;
         sw_q    <= 1'b1;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
         cand_q  <= cand_d;
         stab_q  <= stab_d;
         state_q <= state_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         hold_q  <= hold_d;
         ui_q    <= ui_d;
         uio_q   <= uio_d;
         drst_q  <= drst_d;
         sw_q    <= sw_d;
      end
   end

   assign ui_out         = ui_q;
   assign uio_out        = uio_q;
   assign design_rst_out = drst_q;
   assign design_sel_out = cur_q;
   assign switching_out  = sw_q;

endmodule

// File: tb/tb_input_demux.sv
// Scoreboard bench for input_demux: a 16-slot instance for routing/switching and a
// 12-slot instance for the out-of-range select case.
module tb_input_demux;

   logic         clk;
   logic         rst;
   logic [3:0]   sel16, sel12;
   logic [7:0]   ui_in, uio_in;

   logic [127:0] ui16, uio16;
   logic [15:0]  drst16;
   logic [3:0]   selo16;
   logic         sw16;

   logic [95:0]  ui12, uio12;
   logic [11:0]  drst12;
   logic [3:0]   selo12;
   logic         sw12;

   int cyc = 0;
   int total = 0;
   int bad = 0;

   typedef struct {
      string        nm;
      int           stamp;
      int           inst;
      logic [15:0]  r;
      logic [3:0]   s;
      logic         sw;
      logic [127:0] u;
      logic [127:0] uo;
   } exp_t;

   exp_t q[$];

   input_demux #(.NUM_DESIGNS(16)) dut16 (
      .clk(clk), .rst(rst), .design_sel_in(sel16), .ui_in(ui_in), .uio_in(uio_in),
      .ui_out(ui16), .uio_out(uio16), .design_rst_out(drst16),
      .design_sel_out(selo16), .switching_out(sw16)
   );

   input_demux #(.NUM_DESIGNS(12)) dut12 (
      .clk(clk), .rst(rst), .design_sel_in(sel12), .ui_in(ui_in), .uio_in(uio_in),
      .ui_out(ui12), .uio_out(uio12), .design_rst_out(drst12),
      .design_sel_out(selo12), .switching_out(sw12)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] slot(input int k, input logic [7:0] v);
      logic [127:0] t;
      t = 128'(v);
      return t << (k * 8);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string nm, input int inst, input logic [15:0] r,
                       input logic [3:0] s, input logic sw, input logic [127:0] u,
                       input logic [127:0] uo);
      exp_t e;
      e.nm = nm; e.stamp = cyc; e.inst = inst;
      e.r = r; e.s = s; e.sw = sw; e.u = u; e.uo = uo;
      q.push_back(e);
   endtask

   task automatic chk(input string nm, input int n, input logic [15:0] r, input logic [3:0] s,
                      input logic sw, input logic [127:0] u, input logic [127:0] uo);
      repeat (n) begin
         push(nm, 0, r, s, sw, u, uo);
         step();
      end
   endtask

   task automatic chk12(input string nm, input int n, input logic [15:0] r, input logic [3:0] s,
                        input logic sw, input logic [127:0] u, input logic [127:0] uo);
      repeat (n) begin
         push(nm, 1, r, s, sw, u, uo);
         step();
      end
   endtask

   // Monitor: every falling edge, retire the expectations stamped for this cycle.
   initial begin
      exp_t         e;
      logic [15:0]  ar;
      logic [3:0]   as;
      logic         aw;
      logic [127:0] au, auo;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].stamp <= cyc) begin
            e = q.pop_front();
            if (e.inst == 0) begin
               ar = drst16; as = selo16; aw = sw16; au = ui16; auo = uio16;
            end else begin
               ar = {4'b0, drst12}; as = selo12; aw = sw12;
               au = {32'b0, ui12}; auo = {32'b0, uio12};
            end
            total++;
            if (ar !== e.r || as !== e.s || aw !== e.sw || au !== e.u || auo !== e.uo) begin
               bad++;
               $display("FAIL %s cyc=%0d inst=%0d got rst=%h sel=%0d sw=%b ui=%h uio=%h want rst=%h sel=%0d sw=%b ui=%h uio=%h",
                        e.nm, cyc, e.inst, ar, as, aw, au, auo, e.r, e.s, e.sw, e.u, e.uo);
            end
         end
      end
   end

   initial begin
      rst    = 1'b1;
      sel16  = 4'd0;
      sel12  = 4'd0;
      ui_in  = 8'hA5;
      uio_in = 8'h00;

      // Power-up
      step();
      chk("reset", 5, 16'hFFFF, 4'd0, 1'b1, '0, '0);
      rst = 1'b0;
      chk("hold0", 16, 16'hFFFF, 4'd0, 1'b1, '0, '0);
      push("run0_12", 1, 16'h0FFE, 4'd0, 1'b0, slot(0, 8'hA5), '0);
      chk("run0", 1, 16'hFFFE, 4'd0, 1'b0, slot(0, 8'hA5), '0);
      ui_in = 8'h5A;
      chk("lat_old", 1, 16'hFFFE, 4'd0, 1'b0, slot(0, 8'hA5), '0);
      chk("lat_new", 1, 16'hFFFE, 4'd0, 1'b0, slot(0, 8'h5A), '0);

      // Switch 0 -> 5
      uio_in = 8'h3C;
      sel16  = 4'd5;
      chk("pre5", 1, 16'hFFFE, 4'd0, 1'b0, slot(0, 8'h5A), '0);
      chk("pre5", 6, 16'hFFFE, 4'd0, 1'b0, slot(0, 8'h5A), slot(0, 8'h3C));
      chk("drain5", 1, 16'hFFFF, 4'd0, 1'b1, '0, '0);
      chk("hold5", 16, 16'hFFFF, 4'd5, 1'b1, '0, '0);
      chk("run5", 3, 16'hFFDF, 4'd5, 1'b0, slot(5, 8'h5A), slot(5, 8'h3C));

      // Glitch reject
      sel16 = 4'd9;
      chk("glitch", 3, 16'hFFDF, 4'd5, 1'b0, slot(5, 8'h5A), slot(5, 8'h3C));
      sel16 = 4'd5;
      chk("glitch", 12, 16'hFFDF, 4'd5, 1'b0, slot(5, 8'h5A), slot(5, 8'h3C));

      // Change during HOLD_RST: 2 requested, then 7 on the 4th hold cycle
      sel16 = 4'd2;
      chk("pre2", 7, 16'hFFDF, 4'd5, 1'b0, slot(5, 8'h5A), slot(5, 8'h3C));
      chk("drain2", 1, 16'hFFFF, 4'd5, 1'b1, '0, '0);
      chk("hold2", 3, 16'hFFFF, 4'd2, 1'b1, '0, '0);
      sel16 = 4'd7;
      chk("hold2", 13, 16'hFFFF, 4'd2, 1'b1, '0, '0);
      chk("run2", 1, 16'hFFFB, 4'd2, 1'b0, slot(2, 8'h5A), slot(2, 8'h3C));
      chk("drain7", 1, 16'hFFFF, 4'd2, 1'b1, '0, '0);
      chk("hold7", 16, 16'hFFFF, 4'd7, 1'b1, '0, '0);
      chk("run7", 3, 16'hFF7F, 4'd7, 1'b0, slot(7, 8'h5A), slot(7, 8'h3C));

      // Reset on the 8th HOLD_RST cycle of a switch to 3
      sel16 = 4'd3;
      chk("pre3", 7, 16'hFF7F, 4'd7, 1'b0, slot(7, 8'h5A), slot(7, 8'h3C));
      chk("drain3", 1, 16'hFFFF, 4'd7, 1'b1, '0, '0);
      chk("hold3", 7, 16'hFFFF, 4'd3, 1'b1, '0, '0);
      rst = 1'b1;
      repeat (3) begin
         push("midrst12", 1, 16'h0FFF, 4'd0, 1'b1, '0, '0);
         chk("midrst", 1, 16'hFFFF, 4'd0, 1'b1, '0, '0);
      end
      rst = 1'b0;
      chk("rehold0", 16, 16'hFFFF, 4'd0, 1'b1, '0, '0);
      push("rerun0_12", 1, 16'h0FFE, 4'd0, 1'b0, slot(0, 8'h5A), slot(0, 8'h3C));
      chk("rerun0", 1, 16'hFFFE, 4'd0, 1'b0, slot(0, 8'h5A), slot(0, 8'h3C));
      chk("redrain3", 1, 16'hFFFF, 4'd0, 1'b1, '0, '0);
      chk("rehold3", 16, 16'hFFFF, 4'd3, 1'b1, '0, '0);
      chk("rerun3", 2, 16'hFFF7, 4'd3, 1'b0, slot(3, 8'h5A), slot(3, 8'h3C));

      // Out-of-range select on the 12-slot instance
      sel12 = 4'd14;
      chk12("pre14", 7, 16'h0FFE, 4'd0, 1'b0, slot(0, 8'h5A), slot(0, 8'h3C));
      chk12("drain14", 1, 16'h0FFF, 4'd0, 1'b1, '0, '0);
      chk12("hold14", 16, 16'h0FFF, 4'd14, 1'b1, '0, '0);
      chk12("run14", 4, 16'h0FFF, 4'd14, 1'b0, '0, '0);

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain_queue got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
